// File: rtl/bcd_updown_counter_n_pkg.sv
// Shared constants and BCD helpers for the multi-digit up/down counter.
package bcd_cntr_pkg;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] BCD_MIN    = 4'd0;
  localparam int         DIGIT_W    = 4;
  // Widest counter the all_bcd helper can inspect; DIGITS must not exceed it.
  localparam int         MAX_DIGITS = 16;

  // True when a nibble holds a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

  // True when the low n nibbles of v are all legal decimal digits.
  function automatic logic all_bcd(input logic [DIGIT_W*MAX_DIGITS-1:0] v,
                                   input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < int'(n)) && !is_bcd(v[DIGIT_W*i +: DIGIT_W])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_n_if.sv
// Control/status bundle between the counter and its user.
//
// Handshake: there is no valid/ready pair. clear, load and count_en are
// single-cycle requests sampled on every rising clk edge and always accepted
// (no back-pressure); priority is clear > load > count_en and the losers of
// a cycle are dropped. count/boundary_hit/load_err are registered, tc is
// combinational from count and count_up.
interface bcd_updown_counter_n_if #(
  parameter int DIGITS = 4
);
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic                  count_en;
  logic                  count_up;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  boundary_hit;
  logic                  load_err;

  modport master (
    output clear, load, data_in, count_en, count_up,
    input  count, tc, boundary_hit, load_err
  );

  modport slave (
    input  clear, load, data_in, count_en, count_up,
    output count, tc, boundary_hit, load_err
  );
endinterface

// File: rtl/bcd_updown_counter_n_digit_cell.sv
// One decade cell: holds a single BCD digit and steps it up or down when told.
module bcd_digit_cell
  import bcd_cntr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] d,
  input  logic               step,
  input  logic               up,
  input  logic               hold,
  output logic [DIGIT_W-1:0] q,
  output logic               at_end
);

  logic [DIGIT_W-1:0] r_q;

  // Digit register: clear, then load, then a single wrap-around step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= BCD_MIN;
    end else if (clr) begin
      r_q <= BCD_MIN;
    end else if (ld) begin
      r_q <= d;
    end else if (step && !hold) begin
      if (up) r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
      else    r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q      = r_q;
  // Digit sits at the value that makes it roll over on the next step.
  assign at_end = up ? (r_q == BCD_MAX) : (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit BCD up/down counter with validated load, sync clear and
// wrap/saturate behaviour at the ends of the range.
module bcd_updown_counter_n
  import bcd_cntr_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_updown_counter_n_if.slave   bus
);

  logic [DIGITS-1:0]              w_at_end;
  logic [DIGITS-1:0]              w_carry;
  logic [DIGITS-1:0]              w_step;
  logic [DIGIT_W*DIGITS-1:0]      w_count;
  logic [DIGIT_W*MAX_DIGITS-1:0]  w_data_ext;
  logic                           w_tc;
  logic                           w_hold;
  logic                           w_load_ok;
  logic                           w_do_load;
  logic                           w_do_count;
  logic                           r_boundary_hit;
  logic                           r_load_err;

  // Widen the load value so the package validator can scan it.
  always_comb begin
    w_data_ext                   = '0;
    w_data_ext[4*DIGITS-1:0]     = bus.data_in;
  end

  assign w_load_ok  = all_bcd(w_data_ext, DIGITS);
  assign w_do_load  = !bus.clear && bus.load && w_load_ok;
  assign w_do_count = !bus.clear && !bus.load && bus.count_en;

  // Terminal count: every digit at its roll-over value for the current direction.
  assign w_tc   = &w_at_end;
  // In saturate mode the whole chain freezes when a step would leave the range.
  assign w_hold = SATURATE && w_tc;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      // Carry/borrow into digit gi: every lower digit is at its end value.
      if (gi == 0) begin : g_c0
        assign w_carry[gi] = 1'b1;
      end else begin : g_cn
        assign w_carry[gi] = w_carry[gi-1] && w_at_end[gi-1];
      end

      assign w_step[gi] = w_do_count && !w_hold && w_carry[gi];

      bcd_digit_cell u_cell (
        .clk    (clk),
        .reset  (reset),
        .clr    (bus.clear),
        .ld     (w_do_load),
        .d      (bus.data_in[DIGIT_W*gi +: DIGIT_W]),
        .step   (w_step[gi]),
        .up     (bus.count_up),
        .hold   (w_hold),
        .q      (w_count[DIGIT_W*gi +: DIGIT_W]),
        .at_end (w_at_end[gi])
      );
    end
  endgenerate

  // Single-cycle status pulses for a boundary step and a rejected load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_boundary_hit <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_boundary_hit <= w_do_count && w_tc;
      r_load_err     <= !bus.clear && bus.load && !w_load_ok;
    end
  end

  assign bus.count        = w_count;
  assign bus.tc           = w_tc;
  assign bus.boundary_hit = r_boundary_hit;
  assign bus.load_err     = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: three builds (4-digit wrap, 4-digit
// saturate, 1-digit wrap) share one stimulus stream and are compared against
// an integer-valued reference model.
module tb_bcd_updown_counter_n;

  logic clk;
  logic reset;

  bcd_updown_counter_n_if #(.DIGITS(4)) bus_w ();
  bcd_updown_counter_n_if #(.DIGITS(4)) bus_s ();
  bcd_updown_counter_n_if #(.DIGITS(1)) bus_1 ();

  bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u_dut_w (
    .clk(clk), .reset(reset), .bus(bus_w));
  bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .bus(bus_s));
  bcd_updown_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_dut_1 (
    .clk(clk), .reset(reset), .bus(bus_1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks;
  int n_pass;
  logic [17:0] exp_q[$];   // {boundary_hit, load_err, count}
  int m_val[3];            // model count as a plain integer
  int m_nd[3];
  bit m_sat[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int max_of(input int nd);
    int r;
    r = 1;
    for (int i = 0; i < nd; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v, input int nd);
    int r;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x, input int nd);
    logic [15:0] r;
    int t;
    r = '0;
    t = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v, input int nd);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Advance model k by one clock edge and return {boundary_hit, load_err, count}.
  function automatic logic [17:0] model_step(input int k, input bit clr, input bit ld,
                                             input logic [15:0] d, input bit en, input bit up);
    bit bh, le;
    int mx;
    bh = 1'b0;
    le = 1'b0;
    mx = max_of(m_nd[k]);
    if (clr) begin
      m_val[k] = 0;
    end else if (ld) begin
      if (bcd_ok(d, m_nd[k])) m_val[k] = bcd2int(d, m_nd[k]);
      else le = 1'b1;
    end else if (en) begin
      if (up) begin
        if (m_val[k] == mx) begin
          bh = 1'b1;
          if (!m_sat[k]) m_val[k] = 0;
        end else m_val[k] = m_val[k] + 1;
      end else begin
        if (m_val[k] == 0) begin
          bh = 1'b1;
          if (!m_sat[k]) m_val[k] = mx;
        end else m_val[k] = m_val[k] - 1;
      end
    end
    return {bh, le, int2bcd(m_val[k], m_nd[k])};
  endfunction

  function automatic bit model_tc(input int k, input bit up);
    return up ? (m_val[k] == max_of(m_nd[k])) : (m_val[k] == 0);
  endfunction

  // ---------------- DUT observation ----------------
  function automatic logic [15:0] obs_count(input int k);
    case (k)
      0:       return bus_w.count;
      1:       return bus_s.count;
      default: return {12'h000, bus_1.count};
    endcase
  endfunction

  function automatic logic [2:0] obs_flags(input int k);  // {tc, bh, le}
    case (k)
      0:       return {bus_w.tc, bus_w.boundary_hit, bus_w.load_err};
      1:       return {bus_s.tc, bus_s.boundary_hit, bus_s.load_err};
      default: return {bus_1.tc, bus_1.boundary_hit, bus_1.load_err};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input bit clr, input bit ld, input logic [15:0] d,
                            input bit en, input bit up);
    bus_w.clear = clr; bus_w.load = ld; bus_w.data_in = d;      bus_w.count_en = en; bus_w.count_up = up;
    bus_s.clear = clr; bus_s.load = ld; bus_s.data_in = d;      bus_s.count_en = en; bus_s.count_up = up;
    bus_1.clear = clr; bus_1.load = ld; bus_1.data_in = d[3:0]; bus_1.count_en = en; bus_1.count_up = up;
  endtask

  // Apply one cycle of requests, check tc before the edge and all
  // registered outputs just after it.
  task automatic drive_cycle(input bit clr, input bit ld, input logic [15:0] d,
                             input bit en, input bit up);
    logic [17:0] e;
    logic [2:0]  f;
    set_inputs(clr, ld, d, en, up);
    #1;
    for (int k = 0; k < 3; k++) begin
      f = obs_flags(k);
      check($sformatf("tc_pre[%0d]", k), 32'(f[2]), 32'(model_tc(k, up)));
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(model_step(k, clr, ld, d, en, up));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      f = obs_flags(k);
      check($sformatf("count[%0d]", k), 32'(obs_count(k)), 32'(e[15:0]));
      check($sformatf("boundary_hit[%0d]", k), 32'(f[1]), 32'(e[17]));
      check($sformatf("load_err[%0d]", k), 32'(f[0]), 32'(e[16]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    bit r_clr, r_ld, r_en, r_up;
    logic [15:0] r_d;

    n_checks = 0;
    n_pass   = 0;
    m_nd  = '{4, 4, 1};
    m_sat = '{1'b0, 1'b1, 1'b0};
    m_val = '{0, 0, 0};
    set_inputs(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_count[%0d]", k), 32'(obs_count(k)), 32'h0);
      check($sformatf("rst_flags[%0d]", k), 32'(obs_flags(k)), 32'b000);
    end
    #10 reset = 1'b0;

    // Asynchronous reset in mid-count with a load_err pulse pending.
    drive_cycle(1'b0, 1'b1, 16'h0123, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check("pre_reset_count", 32'(bus_w.count), 32'h0125);
    drive_cycle(1'b0, 1'b1, 16'h12A4, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_count", 32'(bus_w.count), 32'h0);
    check("async_bh", 32'(bus_w.boundary_hit), 32'h0);
    check("async_le", 32'(bus_w.load_err), 32'h0);
    check("async_tc_up", 32'(bus_w.tc), 32'h0);
    set_inputs(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    check("async_tc_down", 32'(bus_w.tc), 32'h1);
    m_val = '{0, 0, 0};
    @(negedge clk);
    reset = 1'b0;

    // Up carry and wrap.
    drive_cycle(1'b0, 1'b1, 16'h0199, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check("carry_0200", 32'(bus_w.count), 32'h0200);
    drive_cycle(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    check("tc_at_9999", 32'(bus_w.tc), 32'h1);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check("wrap_0000", 32'(bus_w.count), 32'h0000);
    check("wrap_bh", 32'(bus_w.boundary_hit), 32'h1);
    check("sat_hold_9999", 32'(bus_s.count), 32'h9999);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("bh_one_cycle", 32'(bus_w.boundary_hit), 32'h0);

    // Down borrow, wrap and saturate.
    drive_cycle(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("borrow_0999", 32'(bus_w.count), 32'h0999);
    drive_cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("down_wrap_9999", 32'(bus_w.count), 32'h9999);
    check("down_sat_0000", 32'(bus_s.count), 32'h0000);
    check("down_sat_bh", 32'(bus_s.boundary_hit), 32'h1);

    // Rejected load, then clear winning over load and count_en.
    drive_cycle(1'b0, 1'b1, 16'h0042, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 16'h12A4, 1'b1, 1'b1);
    check("bad_load_keep", 32'(bus_w.count), 32'h0042);
    check("bad_load_err", 32'(bus_w.load_err), 32'h1);
    drive_cycle(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
    check("prio_clear", 32'(bus_w.count), 32'h0000);
    check("prio_clear_le", 32'(bus_w.load_err), 32'h0);
    drive_cycle(1'b0, 1'b1, 16'h0500, 1'b1, 1'b1);
    check("prio_load", 32'(bus_w.count), 32'h0500);

    // 100 up steps from zero: the 1-digit build wraps ten times.
    drive_cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      if (bus_1.boundary_hit) pulses++;
    end
    check("d1_count", 32'(bus_1.count), 32'h0);
    check("d1_pulses", 32'(pulses), 32'd10);
    check("d4_after_100", 32'(bus_w.count), 32'h0100);

    // Randomised traffic, with loads biased towards the range ends.
    for (int i = 0; i < 400; i++) begin
      r_clr = ($urandom_range(0, 24) == 0);
      r_ld  = ($urandom_range(0, 6) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_up  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       r_d = 16'($urandom_range(0, 65535));
        1:       r_d = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
        default: r_d = int2bcd($urandom_range(0, 9999), 4);
      endcase
      drive_cycle(r_clr, r_ld, r_d, r_en, r_up);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
